// File: rtl/counter_seq_prog_pkg.sv
// Shared sizing, direction encoding and table defaults for the programmable
// sequence counter.
package counter_seq_pkg;

  localparam int CSP_W = 3;

  function automatic int unsigned depth_of(input int unsigned w);
    return 32'd1 << w;
  endfunction

  localparam int CSP_DEPTH = int'(depth_of(CSP_W));

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Reset contents of the sequence table: entry i holds i, so an
  // unprogrammed table makes led mirror idx.
  function automatic int unsigned default_entry(input int unsigned i);
    return i;
  endfunction

endpackage

// File: rtl/counter_seq_prog_if.sv
// Control/data bundle between a driver and the sequence counter.
interface counter_seq_prog_if #(
  parameter int W = counter_seq_pkg::CSP_W
);
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_idx;
  logic         wr_en;
  logic [W-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         last_we;
  logic [W-1:0] last_data;
  logic [W-1:0] led;
  logic [W-1:0] idx;
  logic         wrap;

  modport master (
    output en, dir, load, load_idx, wr_en, wr_addr, wr_data, last_we, last_data,
    input  led, idx, wrap
  );

  modport slave (
    input  en, dir, load, load_idx, wr_en, wr_addr, wr_data, last_we, last_data,
    output led, idx, wrap
  );
endinterface

// File: rtl/counter_seq_prog_seq_table.sv
// DEPTH x W register file: synchronous write, asynchronous read,
// synchronous reset back to the default (identity) contents.
module seq_table
  import counter_seq_pkg::*;
#(
  parameter int W     = CSP_W,
  parameter int DEPTH = 2**W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= W'(default_entry(i));
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read is combinational so a write becomes visible the cycle after its edge.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/counter_seq_prog.sv
// Programmable sequence counter: an index walks 0..last (up or down, with
// wrap) and led shows the table entry the index points at.
module counter_seq_prog
  import counter_seq_pkg::*;
#(
  parameter int W = CSP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  counter_seq_prog_if.slave bus
);

  localparam int DEPTH = 2**W;

  logic [W-1:0] idx_q;
  logic [W-1:0] last_q;
  logic         wrap_q;
  logic [W-1:0] step_idx;
  logic         step_wrap;
  dir_e         dir;

  assign dir = dir_e'(bus.dir);

  // Out-of-range indices (idx > last, e.g. after a load) fold back through
  // the wrap branches rather than counting through the unused region.
  always_comb begin
    step_idx  = idx_q;
    step_wrap = 1'b0;
    if (dir == DIR_UP) begin
      if (idx_q >= last_q) begin
        step_idx  = '0;
        step_wrap = 1'b1;
      end else begin
        step_idx  = idx_q + 1'b1;
      end
    end else begin
      if (idx_q == '0 || idx_q > last_q) begin
        step_idx  = last_q;
        step_wrap = 1'b1;
      end else begin
        step_idx  = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q  <= '0;
      last_q <= '1;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.load) begin
        idx_q <= bus.load_idx;
      end else if (bus.en) begin
        idx_q  <= step_idx;
        wrap_q <= step_wrap;
      end
      // Same-edge step above already used the old last_q.
      if (bus.last_we)
        last_q <= bus.last_data;
    end
  end

  seq_table #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx_q),
    .rd_data (bus.led)
  );

  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_counter_seq_prog.sv
// Directed bench for counter_seq_prog at W = 3.
module tb_counter_seq_prog;

  logic clk;
  logic reset_n;
  int   nvec;
  int   nerr;

  counter_seq_prog_if #(.W(3)) bus ();

  counter_seq_prog #(.W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en        = 1'b0;
    bus.dir       = 1'b0;
    bus.load      = 1'b0;
    bus.load_idx  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.last_we   = 1'b0;
    bus.last_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    nvec++;
    if (bus.idx !== 3'd0 || bus.led !== 3'd0 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reset: idx=%0d led=%0d wrap=%0d, want 0 0 0", bus.idx, bus.led, bus.wrap);
    end
    reset_n = 1'b1;
    tick();
    nvec++;
    if (bus.idx !== 3'd0 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reset_hold: idx=%0d wrap=%0d, want 0 0", bus.idx, bus.wrap);
    end
  endtask

  task automatic test_up_count();
    int exp_led[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      nvec++;
      if (bus.led !== 3'(exp_led[i]) || bus.wrap !== (i == 7)) begin
        nerr++;
        $display("FAIL up_count[%0d]: led=%0d wrap=%0d, want %0d %0d", i, bus.led, bus.wrap, exp_led[i], (i == 7));
      end
    end
    idle();
  endtask

  task automatic test_prog_table();
    int tbl[8]     = '{4, 1, 6, 5, 2, 3, 7, 0};
    int exp_up[8]  = '{1, 6, 5, 2, 3, 7, 0, 4};
    int exp_dn[8]  = '{0, 7, 3, 2, 5, 6, 1, 4};
    do_reset();
    for (int a = 0; a < 8; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(a);
      bus.wr_data = 3'(tbl[a]);
      tick();
    end
    idle();
    bus.load     = 1'b1;
    bus.load_idx = 3'd0;
    tick();
    nvec++;
    if (bus.led !== 3'd4 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL prog_load: led=%0d wrap=%0d, want 4 0", bus.led, bus.wrap);
    end
    idle();
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (bus.led !== 3'(exp_up[i]) || bus.wrap !== (i == 7)) begin
        nerr++;
        $display("FAIL prog_up[%0d]: led=%0d wrap=%0d, want %0d %0d", i, bus.led, bus.wrap, exp_up[i], (i == 7));
      end
    end
    bus.dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (bus.led !== 3'(exp_dn[i]) || bus.wrap !== (i == 0)) begin
        nerr++;
        $display("FAIL prog_down[%0d]: led=%0d wrap=%0d, want %0d %0d", i, bus.led, bus.wrap, exp_dn[i], (i == 0));
      end
    end
    idle();
  endtask

  task automatic test_short_last();
    int exp_up[5] = '{1, 2, 3, 4, 0};
    int exp_dn[6] = '{4, 3, 2, 1, 0, 4};
    do_reset();
    bus.last_we   = 1'b1;
    bus.last_data = 3'd4;
    tick();
    idle();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (bus.idx !== 3'(exp_up[i]) || bus.led !== 3'(exp_up[i]) || bus.wrap !== (i == 4)) begin
        nerr++;
        $display("FAIL last4_up[%0d]: idx=%0d led=%0d wrap=%0d, want %0d %0d", i, bus.idx, bus.led, bus.wrap, exp_up[i], (i == 4));
      end
    end
    bus.dir = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nvec++;
      if (bus.idx !== 3'(exp_dn[i]) || bus.wrap !== (i == 0 || i == 5)) begin
        nerr++;
        $display("FAIL last4_down[%0d]: idx=%0d wrap=%0d, want %0d %0d", i, bus.idx, bus.wrap, exp_dn[i], (i == 0 || i == 5));
      end
    end
    idle();
  endtask

  // Continues from test_short_last: last = 4.
  task automatic test_load_priority();
    bus.load     = 1'b1;
    bus.load_idx = 3'd6;
    bus.en       = 1'b1;
    tick();
    nvec++;
    if (bus.idx !== 3'd6 || bus.led !== 3'd6 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL load_over_en: idx=%0d led=%0d wrap=%0d, want 6 6 0", bus.idx, bus.led, bus.wrap);
    end
    bus.load = 1'b0;
    tick();
    nvec++;
    if (bus.idx !== 3'd0 || bus.wrap !== 1'b1) begin
      nerr++;
      $display("FAIL oob_up: idx=%0d wrap=%0d, want 0 1", bus.idx, bus.wrap);
    end
    bus.load = 1'b1;
    bus.dir  = 1'b1;
    tick();
    nvec++;
    if (bus.idx !== 3'd6 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL load_again: idx=%0d wrap=%0d, want 6 0", bus.idx, bus.wrap);
    end
    bus.load = 1'b0;
    tick();
    nvec++;
    if (bus.idx !== 3'd4 || bus.wrap !== 1'b1) begin
      nerr++;
      $display("FAIL oob_down: idx=%0d wrap=%0d, want 4 1", bus.idx, bus.wrap);
    end
    idle();
  endtask

  task automatic test_hold_and_last_update();
    // idx = 4, last = 4 on entry; held cycles must not move or pulse.
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (bus.idx !== 3'd4 || bus.wrap !== 1'b0) begin
        nerr++;
        $display("FAIL hold[%0d]: idx=%0d wrap=%0d, want 4 0", i, bus.idx, bus.wrap);
      end
    end
    bus.load     = 1'b1;
    bus.load_idx = 3'd3;
    tick();
    bus.load      = 1'b0;
    bus.en        = 1'b1;
    bus.last_we   = 1'b1;
    bus.last_data = 3'd2;
    tick();
    nvec++;
    if (bus.idx !== 3'd4 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL last_same_edge: idx=%0d wrap=%0d, want 4 0", bus.idx, bus.wrap);
    end
    bus.last_we = 1'b0;
    tick();
    nvec++;
    if (bus.idx !== 3'd0 || bus.wrap !== 1'b1) begin
      nerr++;
      $display("FAIL last_next_edge: idx=%0d wrap=%0d, want 0 1", bus.idx, bus.wrap);
    end
    tick();
    tick();
    nvec++;
    if (bus.idx !== 3'd2 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL last2_count: idx=%0d wrap=%0d, want 2 0", bus.idx, bus.wrap);
    end
    idle();
  endtask

  task automatic test_live_write_last0();
    do_reset();
    bus.load     = 1'b1;
    bus.load_idx = 3'd2;
    tick();
    idle();
    nvec++;
    if (bus.led !== 3'd2) begin
      nerr++;
      $display("FAIL live_before: led=%0d, want 2", bus.led);
    end
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd2;
    bus.wr_data = 3'd7;
    tick();
    idle();
    nvec++;
    if (bus.led !== 3'd7 || bus.idx !== 3'd2) begin
      nerr++;
      $display("FAIL live_after: led=%0d idx=%0d, want 7 2", bus.led, bus.idx);
    end
    bus.load      = 1'b1;
    bus.load_idx  = 3'd0;
    bus.last_we   = 1'b1;
    bus.last_data = 3'd0;
    tick();
    idle();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.dir = (i >= 3);
      tick();
      nvec++;
      if (bus.idx !== 3'd0 || bus.led !== 3'd0 || bus.wrap !== 1'b1) begin
        nerr++;
        $display("FAIL last0[%0d]: idx=%0d led=%0d wrap=%0d, want 0 0 1", i, bus.idx, bus.led, bus.wrap);
      end
    end
    idle();
  endtask

  task automatic test_reset_override();
    do_reset();
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd3;
    bus.wr_data   = 3'd5;
    bus.last_we   = 1'b1;
    bus.last_data = 3'd3;
    bus.load      = 1'b1;
    bus.load_idx  = 3'd3;
    tick();
    idle();
    // idx = last = 3: the next enabled up edge would wrap if not reset.
    bus.en        = 1'b1;
    bus.load      = 1'b1;
    bus.load_idx  = 3'd5;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd0;
    bus.wr_data   = 3'd6;
    bus.last_we   = 1'b1;
    bus.last_data = 3'd2;
    reset_n       = 1'b0;
    tick();
    reset_n = 1'b1;
    idle();
    nvec++;
    if (bus.idx !== 3'd0 || bus.led !== 3'd0 || bus.wrap !== 1'b0) begin
      nerr++;
      $display("FAIL reset_override: idx=%0d led=%0d wrap=%0d, want 0 0 0", bus.idx, bus.led, bus.wrap);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      nvec++;
      if (bus.led !== 3'(i % 8) || bus.wrap !== (i == 8)) begin
        nerr++;
        $display("FAIL post_reset[%0d]: led=%0d wrap=%0d, want %0d %0d", i, bus.led, bus.wrap, i % 8, (i == 8));
      end
    end
    idle();
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    reset_n = 1'b0;
    idle();
    test_reset();
    test_up_count();
    test_prog_table();
    test_short_last();
    test_load_priority();
    test_hold_and_last_update();
    test_live_write_last0();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/counter_seq_prog.md
COUNTER_SEQ_PROG -- requirements
Module: counter_seq_prog

Interface
REQ-001 Parameter: W, 3, bit width of sequence values and index; DEPTH = 2**W is a derived localparam (table entries).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  advance index one step per cycle when high.
REQ-005 dir  input  1  count direction: 0 = up, 1 = down.
REQ-006 load  input  1  load index from load_idx this cycle.
REQ-007 load_idx  input  W  index value for load.
REQ-008 wr_en  input  1  write sequence table entry.
REQ-009 wr_addr  input  W  table entry address.
REQ-010 wr_data  input  W  table entry value.
REQ-011 last_we  input  1  write last-index register.
REQ-012 last_data  input  W  new last index (sequence length minus 1).
REQ-013 led  output  W  current sequence value = table[idx].
REQ-014 idx  output  W  current index register.
REQ-015 wrap  output  1  one-cycle pulse, high the cycle after a wrap transition.

Function
REQ-016 State: index register idx, last register, DEPTH x W table, wrap flop; led is combinational read of table[idx], so led follows idx with zero added latency.
REQ-017 Priority per edge: reset > load > en; en low and load low holds idx.
REQ-018 Up step: idx >= last -> idx = 0 (wrap), else idx + 1.
REQ-019 Down step: idx == 0 or idx > last -> idx = last (wrap), else idx - 1.
REQ-020 wrap asserted for exactly one cycle after each edge that took an REQ-018/019 wrap branch; load never asserts wrap; held idx never asserts wrap.
REQ-021 last = 0: up and down steps both keep idx at 0 and pulse wrap every enabled cycle.
REQ-022 load_idx > last accepted as-is; next step follows REQ-018/019 (up -> 0, down -> last).
REQ-023 Table write: table[wr_addr] <= wr_data at edge; writes independent of en/load/dir; write to entry idx points at changes led in the following cycle.
REQ-024 last_we updates last at edge; new value governs steps from the next edge; same-edge step uses old last.
REQ-025 Index arithmetic is W-bit unsigned; no carry or borrow outside REQ-018/019.

Reset
REQ-026 reset_n low at an edge: idx = 0, last = DEPTH-1, wrap = 0, table[i] = i for all i; led therefore 0.
REQ-027 Reset overrides load, en, wr_en, last_we on the same edge; mid-run reset discards programmed table.

Structure
REQ-028 Package counter_seq_pkg holds default W, DEPTH derivation and the default-entry function (entry i -> i).
REQ-029 One sub-module, seq_table: DEPTH x W register file, synchronous write, asynchronous read, synchronous reset to defaults.
REQ-030 Step/wrap logic lives in counter_seq_prog; no other hierarchy.

Verification (W = 3)
REQ-031 Reset then en=1, dir=0 for 9 cycles -> led 1,2,3,4,5,6,7,0,1; wrap high only the cycle after 7->0.
REQ-032 Write table 0..7 = 4,1,6,5,2,3,7,0, load idx 0, en=1 -> led 4,1,6,5,2,3,7,0,4; then dir=1 -> led steps 0,7,3,2,5,6,1,4 order reversed.
REQ-033 last=4, from idx 0 up -> idx 1,2,3,4,0 with wrap after 4->0; dir=1 from 0 -> idx 4,3,2,1,0,4.
REQ-034 load=1,load_idx=6 with en=1 same edge -> idx 6, no wrap; last=4: next up step -> 0 + wrap; alternate run down -> 4 + wrap.
REQ-035 en=0, write table[idx=2] = 7 -> led changes 2->7 next cycle; last=0 with en=1 -> idx stays 0, wrap every cycle.
REQ-036 Reset asserted mid-run with load, wr_en, last_we high -> idx 0, last 7, table identity, led 0, wrap 0 next cycle.
